// File: rtl/program_loader.sv
// Streams instruction words into the instruction memory from a programmable base address.
// The core is held in reset during the load and for a flush window afterwards.
module program_loader #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 12,
    parameter int RESET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_count
);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int SUM_W   = ADDR_W + 2;
    localparam int FLUSH_W = $clog2(RESET_CYCLES + 1);
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    loaded_count_q, loaded_count_d;
    logic [SUM_W-1:0]    end_addr;

    // One extra bit of headroom so a huge word_count cannot wrap past the bounds check.
    assign end_addr = SUM_W'(base_addr) + SUM_W'(word_count);

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        count_d        = count_q;
        idx_d          = idx_q;
        flush_cnt_d    = flush_cnt_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = 1'b0;
        error_d        = error_q;
        loaded_count_d = loaded_count_q;
        cpu_reset_d    = (state_q != RUN);

        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    base_d         = base_addr;
                    count_d        = word_count;
                    idx_d          = '0;
                    error_d        = 1'b0;
                    loaded_count_d = '0;
                    if (end_addr > DEPTH) begin
                        error_d = 1'b1;
                    end else if (word_count == '0) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_W'(RESET_CYCLES);
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (in_valid) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = ADDR_W'({1'b0, base_q} + idx_q);
                    mem_wdata_d    = in_data;
                    idx_d          = idx_q + CNT_W'(1);
                    loaded_count_d = loaded_count_q + CNT_W'(1);
                    if (idx_q == count_q - CNT_W'(1)) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_W'(RESET_CYCLES);
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                if (flush_cnt_q <= FLUSH_W'(1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            count_q        <= '0;
            idx_q          <= '0;
            flush_cnt_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            loaded_count_q <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            flush_cnt_q    <= flush_cnt_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
            loaded_count_q <= loaded_count_d;
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q == LOAD) || (state_q == FLUSH);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued at each accepted transfer
// and compared by a monitor when the memory write appears.
module tb_program_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int RESET_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   loaded_count;

    int n_checks = 0;
    int n_fails  = 0;
    int n_writes = 0;
    int cyc_n    = 0;
    int wr_first = -1;
    int wr_last  = -1;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] words [8];

    program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    // Write monitor: every observed memory write must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        cyc_n++;
        if (!reset && mem_we) begin
            n_writes++;
            if (wr_first < 0) wr_first = cyc_n;
            wr_last = cyc_n;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_fails++;
                    $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end else begin
                    $display("[%0t] write addr=%h data=%h", $time, mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start = 1'b1;
        base_addr = b;
        word_count = c;
        tick();
        start = 1'b0;
    endtask

    // Presents n words; pat gives in_valid per cycle (pat_len 0 = always valid).
    // abort_at = transfer index on which abort is raised alongside in_valid (-1 = none).
    task automatic stream(input logic [ADDR_W-1:0] b, input int n, input logic [15:0] pat,
                          input int pat_len, input int abort_at);
        int k = 0;
        int cyc = 0;
        logic [ADDR_W-1:0] a;
        while (k < n && cyc < 200) begin
            in_valid = (pat_len == 0) ? 1'b1 : pat[cyc % pat_len];
            in_data  = words[k];
            abort    = (abort_at == k) && in_valid;
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (abort) begin
                    k = n;
                end else begin
                    a = b + k[ADDR_W-1:0];
                    exp_q.push_back({a, words[k]});
                    k++;
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        abort = 1'b0;
        if (cyc >= 200) begin
            n_checks++;
            n_fails++;
            $display("FAIL stream_timeout: got %0d of %0d words accepted, required all", k, n);
        end
    endtask

    // Called in the cycle after the FLUSH entry edge; measures the release sequence.
    task automatic wait_release(output int hi, output int busy_n, output int done_n, output int done_at);
        int cyc = 0;
        hi = 0;
        busy_n = busy ? 1 : 0;
        done_n = 0;
        done_at = -1;
        while (cyc < 50) begin
            tick();
            cyc++;
            if (done) begin
                done_n++;
                done_at = cyc;
            end
            if (!cpu_reset) break;
            hi++;
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL reset_cpu_reset: got %b, required 1", cpu_reset); end
        n_checks++; if (mem_we !== 1'b0) begin n_fails++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_addr !== '0) begin n_fails++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_fails++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fails++; $display("FAIL reset_error: got %b, required 0", error); end
        n_checks++; if (loaded_count !== '0) begin n_fails++; $display("FAIL reset_loaded_count: got %0d, required 0", loaded_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        tick();
        tick();
        reset = 1'b0;
        tick();
        $display("[%0t] reset checked", $time);
    endtask

    task automatic test_bounds();
        int w0, hi, bn, dn, da;
        w0 = n_writes;
        pulse_start(12'hFFE, 13'd4);
        n_checks++; if (error !== 1'b1) begin n_fails++; $display("FAIL bounds_error: got %b, required 1", error); end
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL bounds_idle: got in_ready=%b busy=%b, required 0 0", in_ready, busy); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL bounds_cpu_reset: got %b, required 1", cpu_reset); end
        tick(); tick(); tick();
        n_checks++; if (n_writes != w0) begin n_fails++; $display("FAIL bounds_no_write: got %0d writes, required 0", n_writes - w0); end
        $display("[%0t] bounds reject base=ffe count=4", $time);
        // Exactly fills the top of memory.
        pulse_start(12'hFFC, 13'd4);
        n_checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin n_fails++; $display("FAIL fit_start: got error=%b in_ready=%b, required 0 1", error, in_ready); end
        stream(12'hFFC, 4, 16'h0, 0, -1);
        wait_release(hi, bn, dn, da);
        n_checks++; if (n_writes - w0 != 4) begin n_fails++; $display("FAIL fit_writes: got %0d, required 4", n_writes - w0); end
        n_checks++; if (loaded_count !== 13'd4) begin n_fails++; $display("FAIL fit_loaded_count: got %0d, required 4", loaded_count); end
        n_checks++; if (dn != 1) begin n_fails++; $display("FAIL fit_done: got %0d pulses, required 1", dn); end
    endtask

    task automatic test_basic();
        int w0, hi, bn, dn, da;
        w0 = n_writes;
        wr_first = -1;
        pulse_start(12'h020, 13'd4);
        stream(12'h020, 4, 16'h0, 0, -1);
        wait_release(hi, bn, dn, da);
        n_checks++; if (n_writes - w0 != 4) begin n_fails++; $display("FAIL basic_writes: got %0d, required 4", n_writes - w0); end
        n_checks++; if (wr_last - wr_first != 3) begin n_fails++; $display("FAIL basic_consecutive: got span %0d, required 3", wr_last - wr_first); end
        n_checks++; if (hi != RESET_CYCLES) begin n_fails++; $display("FAIL basic_reset_hold: got %0d cycles, required %0d", hi, RESET_CYCLES); end
        n_checks++; if (bn != RESET_CYCLES) begin n_fails++; $display("FAIL basic_flush_len: got %0d busy cycles, required %0d", bn, RESET_CYCLES); end
        n_checks++; if (dn != 1 || da != RESET_CYCLES) begin n_fails++; $display("FAIL basic_done: got %0d pulses at %0d, required 1 at %0d", dn, da, RESET_CYCLES); end
        n_checks++; if (loaded_count !== 13'd4) begin n_fails++; $display("FAIL basic_loaded_count: got %0d, required 4", loaded_count); end
        n_checks++; if (cpu_reset !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL basic_run: got cpu_reset=%b busy=%b, required 0 0", cpu_reset, busy); end
    endtask

    task automatic test_backpressure();
        int w0, hi, bn, dn, da;
        w0 = n_writes;
        wr_first = -1;
        pulse_start(12'h020, 13'd4);
        stream(12'h020, 4, 16'b1011001, 7, -1);
        wait_release(hi, bn, dn, da);
        n_checks++; if (n_writes - w0 != 4) begin n_fails++; $display("FAIL bp_writes: got %0d, required 4", n_writes - w0); end
        n_checks++; if (wr_last - wr_first != 6) begin n_fails++; $display("FAIL bp_span: got %0d, required 6", wr_last - wr_first); end
        n_checks++; if (dn != 1 || hi != RESET_CYCLES) begin n_fails++; $display("FAIL bp_release: got done=%0d hold=%0d, required 1 %0d", dn, hi, RESET_CYCLES); end
    endtask

    task automatic test_abort();
        int w0, dn;
        w0 = n_writes;
        dn = 0;
        pulse_start(12'h040, 13'd5);
        stream(12'h040, 5, 16'h0, 0, 2);
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL abort_cpu_reset: got %b, required 1", cpu_reset); end
            tick();
        end
        n_checks++; if (n_writes - w0 != 2) begin n_fails++; $display("FAIL abort_writes: got %0d, required 2", n_writes - w0); end
        n_checks++; if (loaded_count !== 13'd2) begin n_fails++; $display("FAIL abort_loaded_count: got %0d, required 2", loaded_count); end
        n_checks++; if (error !== 1'b1) begin n_fails++; $display("FAIL abort_error: got %b, required 1", error); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fails++; $display("FAIL abort_idle: got busy=%b in_ready=%b, required 0 0", busy, in_ready); end
        n_checks++; if (dn != 0) begin n_fails++; $display("FAIL abort_done: got %0d pulses, required 0", dn); end
        $display("[%0t] abort after 2 words", $time);
    endtask

    task automatic test_zero_and_reload();
        int w0, hi, bn, dn, da;
        w0 = n_writes;
        pulse_start(12'h100, 13'd0);
        wait_release(hi, bn, dn, da);
        n_checks++; if (n_writes != w0) begin n_fails++; $display("FAIL zero_writes: got %0d, required 0", n_writes - w0); end
        n_checks++; if (bn != RESET_CYCLES) begin n_fails++; $display("FAIL zero_flush_len: got %0d, required %0d", bn, RESET_CYCLES); end
        n_checks++; if (dn != 1 || da != RESET_CYCLES) begin n_fails++; $display("FAIL zero_done: got %0d at %0d, required 1 at %0d", dn, da, RESET_CYCLES); end
        n_checks++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin n_fails++; $display("FAIL zero_run: got cpu_reset=%b error=%b, required 0 0", cpu_reset, error); end
        pulse_start(12'h200, 13'd1);
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reload_load: got in_ready=%b, required 1", in_ready); end
        tick();
        n_checks++; if (cpu_reset !== 1'b1) begin n_fails++; $display("FAIL reload_cpu_reset: got %b, required 1", cpu_reset); end
        stream(12'h200, 1, 16'h0, 0, -1);
        wait_release(hi, bn, dn, da);
        n_checks++; if (n_writes - w0 != 1 || loaded_count !== 13'd1) begin n_fails++; $display("FAIL reload_writes: got %0d count=%0d, required 1 1", n_writes - w0, loaded_count); end
        n_checks++; if (dn != 1 || cpu_reset !== 1'b0) begin n_fails++; $display("FAIL reload_run: got done=%0d cpu_reset=%b, required 1 0", dn, cpu_reset); end
    endtask

    task automatic test_reset_mid_load();
        pulse_start(12'h300, 13'd6);
        stream(12'h300, 2, 16'h0, 0, -1);
        pulse_start(12'h010, 13'd1);
        n_checks++; if (in_ready !== 1'b1 || loaded_count !== 13'd2) begin n_fails++; $display("FAIL ignored_start: got in_ready=%b count=%0d, required 1 2", in_ready, loaded_count); end
        stream(12'h302, 1, 16'h0, 0, -1);
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL latched_count: got in_ready=%b, required 1", in_ready); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0 || cpu_reset !== 1'b1) begin n_fails++; $display("FAIL async_reset_out: got mem_we=%b cpu_reset=%b, required 0 1", mem_we, cpu_reset); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fails++; $display("FAIL async_reset_state: got busy=%b in_ready=%b, required 0 0", busy, in_ready); end
        n_checks++; if (loaded_count !== '0 || mem_addr !== '0) begin n_fails++; $display("FAIL async_reset_regs: got count=%0d addr=%h, required 0 0", loaded_count, mem_addr); end
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b0 || cpu_reset !== 1'b1) begin n_fails++; $display("FAIL post_reset_idle: got in_ready=%b cpu_reset=%b, required 0 1", in_ready, cpu_reset); end
        $display("[%0t] async reset during load", $time);
    endtask

    initial begin
        words[0] = 16'h09FF; words[1] = 16'h975F; words[2] = 16'h639F; words[3] = 16'h1F3D;
        words[4] = 16'h1111; words[5] = 16'h2222; words[6] = 16'h3333; words[7] = 16'h4444;
        test_reset();
        test_bounds();
        test_basic();
        test_backpressure();
        test_abort();
        test_zero_and_reload();
        test_reset_mid_load();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
